fpmul_scheduler: RTL and testbench

FPMUL_SCHEDULER -- requirements
Module: fpmul_scheduler

---
 rtl/fpmul_scheduler.sv | 107 ++++++++++
 tb/tb_fpmul_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_scheduler.sv
// Two-requester front end for a multicycle FP multiplier core: round-robin grant,
// one job in flight, bounded wait on the core with a quiet-NaN error response.
module fpmul_scheduler #(
   parameter int TIMEOUT = 40
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req0_valid,
   input  logic [31:0] i_req0_a,
   input  logic [31:0] i_req0_b,
   input  logic        i_req1_valid,
   input  logic [31:0] i_req1_a,
   input  logic [31:0] i_req1_b,
   output logic        o_req0_ready,
   output logic        o_req1_ready,
   output logic        o_core_start,
   output logic [31:0] o_core_a,
   output logic [31:0] o_core_b,
   input  logic        i_core_done,
   input  logic [31:0] i_core_res,
   output logic        o_rsp_valid,
   output logic        o_rsp_id,
   output logic [31:0] o_rsp_res,
   output logic        o_rsp_err,
   input  logic        i_rsp_ready
);

   localparam logic [31:0] QNAN        = 32'h7FC0_0000;
   localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t      r_state;
   logic        r_last;
   logic        r_job_id;
   logic [7:0]  r_cnt;

   logic        w_pick1;
   logic        w_accept;
   logic [7:0]  w_cnt_nxt;

   // On a tie the requester that did not win last time is chosen.
   assign w_pick1      = (i_req0_valid && i_req1_valid) ? ~r_last : i_req1_valid;
   assign w_accept     = (r_state == S_IDLE) && !i_rst && (i_req0_valid || i_req1_valid);
   assign o_req0_ready = w_accept && !w_pick1;
   assign o_req1_ready = w_accept &&  w_pick1;
   assign w_cnt_nxt    = r_cnt + 8'd1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_last       <= 1'b1;
         r_job_id     <= 1'b0;
         r_cnt        <= 8'd0;
         o_core_start <= 1'b0;
         o_core_a     <= 32'd0;
         o_core_b     <= 32'd0;
         o_rsp_valid  <= 1'b0;
         o_rsp_id     <= 1'b0;
         o_rsp_res    <= 32'd0;
         o_rsp_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state      <= S_ISSUE;
                  o_core_start <= 1'b1;
                  r_last       <= w_pick1;
                  r_job_id     <= w_pick1;
                  o_core_a     <= w_pick1 ? i_req1_a : i_req0_a;
                  o_core_b     <= w_pick1 ? i_req1_b : i_req0_b;
               end
            end
            S_ISSUE: begin
               o_core_start <= 1'b0;
               r_cnt        <= 8'd0;
               r_state      <= S_WAIT;
            end
            S_WAIT: begin
               r_cnt <= w_cnt_nxt;
               // A done arriving on the final allowed cycle still beats the timeout.
               if (i_core_done) begin
                  o_rsp_res   <= i_core_res;
                  o_rsp_err   <= 1'b0;
                  o_rsp_id    <= r_job_id;
                  o_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else if (w_cnt_nxt == TIMEOUT_CNT) begin
                  o_rsp_res   <= QNAN;
                  o_rsp_err   <= 1'b1;
                  o_rsp_id    <= r_job_id;
                  o_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (i_rsp_ready) begin
                  o_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpmul_scheduler.sv
// Randomized bench for fpmul_scheduler against a job-timeline reference model,
// with a few hand-computed pins on latency, grant order and timeout behaviour.
module tb_fpmul_scheduler;

   localparam int TO = 40;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_req0_valid, i_req1_valid;
   logic [31:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
   logic        o_req0_ready, o_req1_ready;
   logic        o_core_start;
   logic [31:0] o_core_a, o_core_b;
   logic        i_core_done;
   logic [31:0] i_core_res;
   logic        o_rsp_valid, o_rsp_id, o_rsp_err;
   logic [31:0] o_rsp_res;
   logic        i_rsp_ready;

   fpmul_scheduler #(.TIMEOUT(TO)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req0_valid(i_req0_valid), .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
      .i_req1_valid(i_req1_valid), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
      .o_req0_ready(o_req0_ready), .o_req1_ready(o_req1_ready),
      .o_core_start(o_core_start), .o_core_a(o_core_a), .o_core_b(o_core_b),
      .i_core_done(i_core_done), .i_core_res(i_core_res),
      .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_res(o_rsp_res),
      .o_rsp_err(o_rsp_err), .i_rsp_ready(i_rsp_ready));

   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int checks = 0;
   int errors = 0;

   // stimulus knobs
   logic        s_rst = 1'b1, s_v0 = 1'b0, s_v1 = 1'b0, s_rr = 1'b1, s_stray = 1'b0;
   logic [31:0] s_a0 = 0, s_b0 = 0, s_a1 = 0, s_b1 = 0, s_cres = 0;
   int          next_lat = 0;   // 0 means the core never answers
   int          done_cyc = -1;

   // reference model: a job is described by its accept cycle and response cycle
   int          cyc = 0;
   bit          m_known = 0, m_prev_rst = 0;
   bit          m_job = 0, m_last = 1;
   int          m_acc = 0, m_rcyc = -1;
   logic        m_id = 0, m_rid = 0, m_rerr = 0;
   logic [31:0] m_ca = 0, m_cb = 0, m_rres = 0;

   // observations of the DUT for the literal pins
   int          p_acc_cyc = 0, p_start_cyc = 0, p_rsp_cyc = 0, p_starts = 0;
   logic [31:0] p_rsp_res = 0;
   logic        p_rsp_err = 0, p_rsp_id = 0, p_prev_rv = 0;
   int          g_log[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic bit model_rv();
      return m_job && (m_rcyc >= 0) && (cyc >= m_rcyc);
   endfunction

   task automatic step();
      int   g;
      bit   acc, exp_st, exp_rv, in_wait;
      logic dn;
      @(negedge i_clk);
      dn           = (cyc == done_cyc) || s_stray;
      i_rst        = s_rst;
      i_req0_valid = s_v0; i_req0_a = s_a0; i_req0_b = s_b0;
      i_req1_valid = s_v1; i_req1_a = s_a1; i_req1_b = s_b1;
      i_rsp_ready  = s_rr;
      i_core_done  = dn;
      i_core_res   = s_cres;
      #1;
      g       = (s_v0 && s_v1) ? (m_last ? 0 : 1) : (s_v1 ? 1 : 0);
      acc     = !m_job && !s_rst && (s_v0 || s_v1);
      exp_st  = m_job && (cyc == m_acc + 1);
      exp_rv  = model_rv();
      in_wait = m_job && (m_rcyc < 0) && (cyc >= m_acc + 2);
      if (m_known) begin
         chk("ready0", o_req0_ready, acc && g == 0);
         chk("ready1", o_req1_ready, acc && g == 1);
         chk("core_start", o_core_start, exp_st);
         chk("core_a", o_core_a, m_ca);
         chk("core_b", o_core_b, m_cb);
         chk("rsp_valid", o_rsp_valid, exp_rv);
         chk("rsp_id", o_rsp_id, m_rid);
         chk("rsp_res", o_rsp_res, m_rres);
         chk("rsp_err", o_rsp_err, m_rerr);
      end
      if (m_prev_rst) begin
         chk("rst_start", o_core_start, 0);
         chk("rst_rsp_valid", o_rsp_valid, 0);
         chk("rst_rsp_res", o_rsp_res, 0);
         chk("rst_core_a", o_core_a, 0);
      end
      // DUT observations
      if (o_req0_ready || o_req1_ready) begin
         g_log.push_back(int'(o_req1_ready));
         p_acc_cyc = cyc;
      end
      if (o_core_start === 1'b1) begin
         p_start_cyc = cyc;
         p_starts++;
      end
      if (o_rsp_valid === 1'b1 && !p_prev_rv) begin
         p_rsp_cyc = cyc; p_rsp_res = o_rsp_res; p_rsp_err = o_rsp_err; p_rsp_id = o_rsp_id;
      end
      p_prev_rv = (o_rsp_valid === 1'b1);
      // model advance across the coming edge
      m_prev_rst = s_rst;
      if (s_rst) begin
         m_known = 1; m_job = 0; m_last = 1; m_rcyc = -1; done_cyc = -1;
         m_ca = 0; m_cb = 0; m_rid = 0; m_rres = 0; m_rerr = 0;
      end else begin
         if (exp_rv && s_rr) m_job = 0;
         if (in_wait) begin
            if (dn) begin
               m_rcyc = cyc + 1; m_rres = s_cres; m_rerr = 0; m_rid = m_id;
            end else if (cyc == m_acc + 1 + TO) begin
               m_rcyc = cyc + 1; m_rres = 32'h7FC00000; m_rerr = 1; m_rid = m_id;
            end
         end
         if (exp_st) done_cyc = (next_lat == 0) ? -1 : cyc + next_lat;
         if (acc) begin
            m_job = 1; m_acc = cyc; m_rcyc = -1; m_last = (g == 1); m_id = (g == 1);
            m_ca = g ? s_a1 : s_a0;
            m_cb = g ? s_b1 : s_b0;
         end
      end
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (m_job && k < budget) begin step(); k++; end
      if (m_job) begin
         checks++; errors++;
         $display("FAIL wait_idle cyc=%0d actual=busy required=idle", cyc);
      end
   endtask

   initial begin
      int base, k, s0;
      // reset
      run(3);
      s_rst = 0;
      run(2);

      // tie straight after reset: 0,1,0,1
      base = g_log.size();
      s_v0 = 1; s_v1 = 1; s_a0 = 32'h3F800000; s_b0 = 32'h40400000;
      s_a1 = 32'hC0000000; s_b1 = 32'h3F000000; next_lat = 3; s_cres = 32'h12345678;
      k = 0;
      while (g_log.size() < base + 4 && k < 200) begin step(); k++; s_cres = $urandom; end
      s_v0 = 0; s_v1 = 0;
      wait_idle(100);
      if (g_log.size() >= base + 4) begin
         for (int i = 0; i < 4; i++) chk("tie_grant", g_log[base+i], i % 2);
      end else begin
         checks++; errors++;
         $display("FAIL tie_grant actual=%0d grants required=4", g_log.size() - base);
      end

      // single job, core answers 5 cycles after start
      s0 = p_starts;
      s_v0 = 1; s_a0 = 32'h3F800000; s_b0 = 32'h40000000; s_cres = 32'h40000000; next_lat = 5;
      step();
      s_v0 = 0;
      wait_idle(100);
      chk("single_latency", p_rsp_cyc - p_acc_cyc, 7);
      chk("single_res", p_rsp_res, 32'h40000000);
      chk("single_id", p_rsp_id, 0);
      chk("single_err", p_rsp_err, 0);
      chk("single_starts", p_starts - s0, 1);

      // stray done while idle
      s_stray = 1; s_cres = 32'hDEADBEEF; run(2); s_stray = 0; run(1);

      // timeout, then a normal job
      s_v1 = 1; s_a1 = 32'h41200000; s_b1 = 32'h41200000; next_lat = 0;
      step();
      s_v1 = 0;
      wait_idle(100);
      chk("timeout_cycles", p_rsp_cyc - p_start_cyc, TO + 1);
      chk("timeout_res", p_rsp_res, 32'h7FC00000);
      chk("timeout_err", p_rsp_err, 1);
      s_v0 = 1; s_cres = 32'h42C80000; next_lat = 3;
      step();
      s_v0 = 0;
      wait_idle(100);
      chk("after_timeout_err", p_rsp_err, 0);
      chk("after_timeout_res", p_rsp_res, 32'h42C80000);

      // backpressure: 10 cycles of held response with both requesters waiting
      s0 = p_starts;
      s_rr = 0; next_lat = 2; s_cres = 32'h40490FDB;
      s_v0 = 1; step(); s_v0 = 0;
      k = 0;
      while (!model_rv() && k < 50) begin step(); k++; end
      s_v0 = 1; s_v1 = 1;
      run(10);
      chk("bp_starts", p_starts - s0, 1);
      s_v0 = 0; s_v1 = 0; s_rr = 1;
      wait_idle(20);

      // done on the timeout cycle itself
      s_v1 = 1; next_lat = TO; s_cres = 32'h3E800000;
      step();
      s_v1 = 0;
      wait_idle(100);
      chk("coinc_cycles", p_rsp_cyc - p_start_cyc, TO + 1);
      chk("coinc_err", p_rsp_err, 0);
      chk("coinc_res", p_rsp_res, 32'h3E800000);

      // reset in WAIT, late done afterwards, then tie goes to requester 0
      s_v1 = 1; next_lat = 0;
      step();
      s_v1 = 0;
      run(6);
      s_rst = 1; step(); s_rst = 0;
      s_stray = 1; step(); s_stray = 0;
      run(5);
      base = g_log.size();
      s_v0 = 1; s_v1 = 1; next_lat = 2;
      k = 0;
      while (g_log.size() == base && k < 20) begin step(); k++; end
      s_v0 = 0; s_v1 = 0;
      if (g_log.size() > base) chk("rst_tie_first", g_log[base], 0);
      else begin
         checks++; errors++;
         $display("FAIL rst_tie_first actual=no_grant required=0");
      end
      wait_idle(100);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         s_v0 = ($urandom_range(0, 2) != 0);
         s_v1 = ($urandom_range(0, 2) != 0);
         s_a0 = $urandom; s_b0 = $urandom; s_a1 = $urandom; s_b1 = $urandom;
         s_cres  = $urandom;
         s_rr    = ($urandom_range(0, 3) != 0);
         s_stray = ($urandom_range(0, 49) == 0);
         s_rst   = ($urandom_range(0, 299) == 0);
         next_lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 44);
         step();
      end
      s_v0 = 0; s_v1 = 0; s_rr = 1; s_stray = 0; s_rst = 0;
      wait_idle(100);
      run(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
